// File: rtl/smi_header_inject_mf_pkg.sv
// Shared definitions for the SMI multi-flit header injector: eofc width,
// write-side FSM encodings and the eofc load mask helper.
package smi_header_inject_mf_pkg;

    localparam int EofcW = 8;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_EMIT_HEAD  = 2'd1;
    localparam logic [1:0] ST_COPY_FRAME = 2'd2;
    localparam logic [1:0] ST_ADD_TAIL   = 2'd3;

    function automatic logic [EofcW-1:0] eofc_mask(input int flit_width);
        return EofcW'(2 * flit_width - 1);
    endfunction

endpackage

// File: rtl/smi_header_inject_mf_fifo.sv
// Show-ahead output buffer: output valid whenever non-empty, head entry presented
// directly from storage; push refused while full.
module smi_header_inject_mf_fifo #(
    parameter int Width     = 136,
    parameter int Depth     = 16,
    parameter int IndexSize = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             i_wr_valid,
    input  logic [Width-1:0] i_wr_data,
    output logic             o_full,
    output logic             o_rd_valid,
    output logic [Width-1:0] o_rd_data,
    input  logic             i_rd_stop
);

    localparam logic [IndexSize-1:0] PtrLast   = IndexSize'(Depth - 1);
    localparam logic [IndexSize-1:0] PtrOne    = IndexSize'(1);
    localparam logic [IndexSize:0]   CountFull = (IndexSize + 1)'(Depth);
    localparam logic [IndexSize:0]   CountOne  = (IndexSize + 1)'(1);

    logic [Width-1:0]     r_mem [Depth];
    logic [IndexSize-1:0] r_wr_ptr;
    logic [IndexSize-1:0] r_rd_ptr;
    logic [IndexSize:0]   r_count;
    logic                 w_push;
    logic                 w_pop;

    function automatic logic [IndexSize-1:0] ptr_next(input logic [IndexSize-1:0] p);
        return (p == PtrLast) ? {IndexSize{1'b0}} : p + PtrOne;
    endfunction

    assign o_full     = (r_count == CountFull);
    assign o_rd_valid = (r_count != {(IndexSize + 1){1'b0}});
    assign o_rd_data  = r_mem[r_rd_ptr];
    assign w_push     = i_wr_valid & ~o_full;
    assign w_pop      = o_rd_valid & ~i_rd_stop;

    // Pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_ptr <= {IndexSize{1'b0}};
            r_rd_ptr <= {IndexSize{1'b0}};
            r_count  <= {(IndexSize + 1){1'b0}};
        end else begin
            if (w_push) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CountOne;
                2'b01:   r_count <= r_count - CountOne;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule

// File: rtl/smi_header_inject_mf.sv
// Prepends a HeadWidth-byte header (any size) to each SMI frame; leftover header
// bytes are carried into the low bytes of the body flits, adding a tail flit if needed.
module smi_header_inject_mf
    import smi_header_inject_mf_pkg::*;
#(
    parameter int FlitWidth     = 16,
    parameter int HeadWidth     = 36,
    parameter int FifoSize      = 16,
    parameter int FifoIndexSize = 4,
    parameter int HeadCountSize = 4
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   headerReady,
    input  logic [HeadWidth*8-1:0] headerData,
    output logic                   headerStop,
    input  logic                   smiInReady,
    input  logic [EofcW-1:0]       smiInEofc,
    input  logic [FlitWidth*8-1:0] smiInData,
    output logic                   smiInStop,
    output logic                   smiOutReady,
    output logic [EofcW-1:0]       smiOutEofc,
    output logic [FlitWidth*8-1:0] smiOutData,
    input  logic                   smiOutStop
);

    localparam int HeadFlits = HeadWidth / FlitWidth;
    localparam int HeadRem   = HeadWidth % FlitWidth;
    localparam int FlitSplit = FlitWidth - HeadRem;
    localparam int FlitBits  = FlitWidth * 8;
    localparam int HoldW     = (HeadFlits + 1) * FlitBits;
    localparam int HoldIdxW  = $clog2(HoldW);
    localparam int CarryW    = (HeadRem == 0) ? 8 : HeadRem * 8;

    localparam logic [EofcW-1:0]         EofcMask   = eofc_mask(FlitWidth);
    localparam logic [EofcW-1:0]         HeadRemE   = EofcW'(HeadRem);
    localparam logic [EofcW-1:0]         FlitSplitE = EofcW'(FlitSplit);
    localparam logic [HeadCountSize-1:0] CntOne     = HeadCountSize'(1);
    localparam logic [HeadCountSize-1:0] CntLast    = HeadCountSize'((HeadFlits == 0) ? 0 : HeadFlits - 1);

    logic                     r_hdr_valid;
    logic [HeadWidth*8-1:0]   r_hdr_data;
    logic                     r_in_valid;
    logic [EofcW-1:0]         r_in_eofc;
    logic [FlitBits-1:0]      r_in_data;
    logic [1:0]               r_state;
    logic [HeadCountSize-1:0] r_cnt;
    logic [HoldW-1:0]         r_hold;
    logic [CarryW-1:0]        r_carry;
    logic [EofcW-1:0]         r_last_eofc;

    logic                     w_hdr_halt;
    logic                     w_in_halt;
    logic                     w_buf_valid;
    logic                     w_buf_full;
    logic                     w_wr;
    logic [FlitBits-1:0]      w_buf_data;
    logic [EofcW-1:0]         w_buf_eofc;
    logic [FlitBits+EofcW-1:0] w_rd_word;
    logic [HoldW-1:0]         w_hdr_ext;
    logic [HoldIdxW-1:0]      w_head_off;
    logic [FlitBits-1:0]      w_head_flit;
    logic [FlitBits-1:0]      w_copy_data;
    logic [EofcW-1:0]         w_copy_eofc;
    logic                     w_copy_tail;
    logic [CarryW-1:0]        w_next_carry;
    logic [FlitBits-1:0]      w_tail_data;
    logic [EofcW-1:0]         w_tail_eofc;

    // Zero padding above the header keeps every flit slice and the carry slice in range.
    assign w_hdr_ext   = {{(HoldW - HeadWidth * 8){1'b0}}, r_hdr_data};
    assign w_head_off  = HoldIdxW'(r_cnt) * HoldIdxW'(FlitBits);
    assign w_head_flit = r_hold[w_head_off +: FlitBits];
    assign w_wr        = w_buf_valid & ~w_buf_full;

    assign headerStop  = r_hdr_valid & w_hdr_halt;
    assign smiInStop   = r_in_valid & w_in_halt;

    generate
        if (HeadRem != 0) begin : g_carry
            assign w_copy_data  = {r_in_data[FlitSplit*8-1:0], r_carry};
            assign w_next_carry = r_in_data[FlitBits-1 -: HeadRem*8];
            assign w_copy_tail  = (r_in_eofc > FlitSplitE);
            assign w_copy_eofc  = ((r_in_eofc == 8'd0) || w_copy_tail) ? 8'd0 : (r_in_eofc + HeadRemE);
            assign w_tail_data  = {{(FlitSplit * 8){1'b0}}, r_carry};
            assign w_tail_eofc  = r_last_eofc - FlitSplitE;
        end else begin : g_nocarry
            assign w_copy_data  = r_in_data;
            assign w_next_carry = r_carry;
            assign w_copy_tail  = 1'b0;
            assign w_copy_eofc  = r_in_eofc;
            assign w_tail_data  = {FlitBits{1'b0}};
            assign w_tail_eofc  = 8'd0;
        end
    endgenerate

    // Write-side selection and input halts per FSM state
    always_comb begin
        w_buf_valid = 1'b0;
        w_buf_data  = {FlitBits{1'b0}};
        w_buf_eofc  = 8'd0;
        w_hdr_halt  = 1'b1;
        w_in_halt   = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_hdr_halt = 1'b0;
            end
            ST_EMIT_HEAD: begin
                w_buf_valid = 1'b1;
                w_buf_data  = w_head_flit;
            end
            ST_COPY_FRAME: begin
                w_buf_valid = r_in_valid;
                w_buf_data  = w_copy_data;
                w_buf_eofc  = w_copy_eofc;
                w_in_halt   = w_buf_full;
            end
            ST_ADD_TAIL: begin
                w_buf_valid = 1'b1;
                w_buf_data  = w_tail_data;
                w_buf_eofc  = w_tail_eofc;
            end
            default: begin
                w_buf_valid = 1'b0;
            end
        endcase
    end

    // Header input register valid
    always_ff @(posedge clk) begin
        if (srst) r_hdr_valid <= 1'b0;
        else if (!(r_hdr_valid && w_hdr_halt)) r_hdr_valid <= headerReady;
    end

    // Header input register data
    always_ff @(posedge clk) begin
        if (!(r_hdr_valid && w_hdr_halt)) r_hdr_data <= headerData;
    end

    // SMI input register valid
    always_ff @(posedge clk) begin
        if (srst) r_in_valid <= 1'b0;
        else if (!(r_in_valid && w_in_halt)) r_in_valid <= smiInReady;
    end

    // SMI input register data; eofc masked to its legal range on load
    always_ff @(posedge clk) begin
        if (!(r_in_valid && w_in_halt)) begin
            r_in_eofc <= smiInEofc & EofcMask;
            r_in_data <= smiInData;
        end
    end

    // Frame FSM; state, count and carry only advance on an accepted buffer write
    always_ff @(posedge clk) begin
        if (srst) begin
            r_state <= ST_IDLE;
            r_cnt   <= {HeadCountSize{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_hdr_valid) begin
                        r_hold  <= w_hdr_ext;
                        r_carry <= w_hdr_ext[HeadFlits*FlitBits +: CarryW];
                        r_cnt   <= {HeadCountSize{1'b0}};
                        r_state <= (HeadFlits == 0) ? ST_COPY_FRAME : ST_EMIT_HEAD;
                    end
                end
                ST_EMIT_HEAD: begin
                    if (w_wr) begin
                        r_cnt <= r_cnt + CntOne;
                        if (r_cnt == CntLast) r_state <= ST_COPY_FRAME;
                    end
                end
                ST_COPY_FRAME: begin
                    if (w_wr) begin
                        r_carry     <= w_next_carry;
                        r_last_eofc <= r_in_eofc;
                        if (r_in_eofc != 8'd0) r_state <= w_copy_tail ? ST_ADD_TAIL : ST_IDLE;
                    end
                end
                ST_ADD_TAIL: begin
                    if (w_wr) r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    smi_header_inject_mf_fifo #(
        .Width    (FlitBits + EofcW),
        .Depth    (FifoSize),
        .IndexSize(FifoIndexSize)
    ) u_out_fifo (
        .clk       (clk),
        .srst      (srst),
        .i_wr_valid(w_buf_valid),
        .i_wr_data ({w_buf_eofc, w_buf_data}),
        .o_full    (w_buf_full),
        .o_rd_valid(smiOutReady),
        .o_rd_data (w_rd_word),
        .i_rd_stop (smiOutStop)
    );

    assign smiOutEofc = w_rd_word[FlitBits +: EofcW];
    assign smiOutData = w_rd_word[FlitBits-1:0];

endmodule

// File: tb/tb_smi_header_inject_mf.sv
// Directed bench for smi_header_inject_mf at FlitWidth=4 with HeadWidth=6 and
// HeadWidth=8 instances; expected flits come from a header||body byte-stream model.
module tb_smi_header_inject_mf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        srst;
    logic        hdr_ready;
    logic [63:0] hdr_data;
    logic        in_ready;
    logic [7:0]  in_eofc;
    logic [31:0] in_data;
    logic        out_stop;
    logic        rnd_stop;
    logic        force_stop;
    int          sel;

    logic        hr6, hr8, ir6, ir8;
    logic        h_stop6, h_stop8, i_stop6, i_stop8, o_rdy6, o_rdy8;
    logic [7:0]  o_eofc6, o_eofc8;
    logic [31:0] o_data6, o_data8;
    logic        h_stop, i_stop, o_rdy;
    logic [7:0]  o_eofc;
    logic [31:0] o_data;

    logic [31:0] q_data [$];
    logic [7:0]  q_eofc [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    assign hr6    = hdr_ready & (sel == 0);
    assign hr8    = hdr_ready & (sel == 1);
    assign ir6    = in_ready & (sel == 0);
    assign ir8    = in_ready & (sel == 1);
    assign h_stop = (sel == 0) ? h_stop6 : h_stop8;
    assign i_stop = (sel == 0) ? i_stop6 : i_stop8;
    assign o_rdy  = (sel == 0) ? o_rdy6  : o_rdy8;
    assign o_eofc = (sel == 0) ? o_eofc6 : o_eofc8;
    assign o_data = (sel == 0) ? o_data6 : o_data8;

    smi_header_inject_mf #(.FlitWidth(4), .HeadWidth(6), .FifoSize(16), .FifoIndexSize(4), .HeadCountSize(4)) u_dut6 (
        .clk(clk), .srst(srst),
        .headerReady(hr6), .headerData(hdr_data[47:0]), .headerStop(h_stop6),
        .smiInReady(ir6), .smiInEofc(in_eofc), .smiInData(in_data), .smiInStop(i_stop6),
        .smiOutReady(o_rdy6), .smiOutEofc(o_eofc6), .smiOutData(o_data6), .smiOutStop(out_stop)
    );

    smi_header_inject_mf #(.FlitWidth(4), .HeadWidth(8), .FifoSize(16), .FifoIndexSize(4), .HeadCountSize(4)) u_dut8 (
        .clk(clk), .srst(srst),
        .headerReady(hr8), .headerData(hdr_data), .headerStop(h_stop8),
        .smiInReady(ir8), .smiInEofc(in_eofc), .smiInData(in_data), .smiInStop(i_stop8),
        .smiOutReady(o_rdy8), .smiOutEofc(o_eofc8), .smiOutData(o_data8), .smiOutStop(out_stop)
    );

    // Output backpressure: random when enabled, otherwise the forced level
    always @(posedge clk) begin
        #1;
        out_stop = rnd_stop ? 1'($urandom_range(0, 1)) : force_stop;
    end

    // Collect every accepted output flit of the selected instance
    always @(negedge clk) begin
        if (o_rdy && !out_stop) begin
            q_data.push_back(o_data);
            q_eofc.push_back(o_eofc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic put_hdr(input logic [63:0] h);
        int k;
        hdr_data  = h;
        hdr_ready = 1'b1;
        k = 0;
        @(negedge clk);
        while (h_stop && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("hdr_accept", 64'(h_stop), 64'd0);
        @(posedge clk);
        #1;
        hdr_ready = 1'b0;
    endtask

    task automatic put_flit(input logic [31:0] d, input logic [7:0] e);
        int k;
        in_data  = d;
        in_eofc  = e;
        in_ready = 1'b1;
        k = 0;
        @(negedge clk);
        while (i_stop && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (k >= 500) chk("flit_accept", 64'(i_stop), 64'd0);
        @(posedge clk);
        #1;
        in_ready = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int k;
        k = 0;
        while (q_data.size() < n && k < 1000) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // Drive one frame and compare the output against the header||body byte stream
    task automatic run_frame(input int hw, input logic [63:0] hdr, input int nfl,
                             input logic [7:0] last_e, input logic [7:0] seed,
                             input string tag, input bit lat);
        logic [7:0]  eb [64];
        logic [31:0] d, ed, m;
        logic [7:0]  b, ee;
        int          tot, nf;
        q_data.delete();
        q_eofc.delete();
        tot = 0;
        for (int i = 0; i < hw; i++) begin
            eb[tot] = hdr[i*8 +: 8];
            tot++;
        end
        put_hdr(hdr);
        if (lat) begin
            @(negedge clk); chk({tag, "_lat0"}, 64'(o_rdy), 64'd0);
            @(negedge clk); chk({tag, "_lat1"}, 64'(o_rdy), 64'd0);
            @(negedge clk); chk({tag, "_lat2"}, 64'(o_rdy), 64'd1);
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < nfl; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (i == nfl - 1 && j >= int'(last_e)) b = 8'hEE;
                else begin
                    b = seed + 8'(i * 4 + j);
                    eb[tot] = b;
                    tot++;
                end
                d[j*8 +: 8] = b;
            end
            put_flit(d, (i == nfl - 1) ? last_e : 8'd0);
        end
        nf = (tot + 3) / 4;
        wait_out(nf);
        chk({tag, "_count"}, 64'(q_data.size()), 64'(nf));
        for (int f = 0; f < nf && f < q_data.size(); f++) begin
            ed = 32'd0;
            m  = 32'd0;
            for (int j = 0; j < 4; j++) begin
                if (f * 4 + j < tot) begin
                    ed[j*8 +: 8] = eb[f*4 + j];
                    m[j*8 +: 8]  = 8'hFF;
                end
            end
            ee = (f == nf - 1) ? 8'(tot - 4 * f) : 8'd0;
            chk($sformatf("%s_data%0d", tag, f), 64'(q_data[f] & m), 64'(ed));
            chk($sformatf("%s_eofc%0d", tag, f), 64'(q_eofc[f]), 64'(ee));
        end
    endtask

    initial begin
        srst = 1'b1; hdr_ready = 1'b0; hdr_data = 64'd0; in_ready = 1'b0;
        in_eofc = 8'd0; in_data = 32'd0; rnd_stop = 1'b0; force_stop = 1'b0; sel = 0;
        repeat (3) @(posedge clk);
        #1;
        srst = 1'b0;
        @(negedge clk);
        chk("rst_out_ready6", 64'(o_rdy6), 64'd0);
        chk("rst_out_ready8", 64'(o_rdy8), 64'd0);
        chk("rst_hdr_stop6", 64'(h_stop6), 64'd0);
        chk("rst_in_stop6", 64'(i_stop6), 64'd0);
        @(posedge clk);
        #1;

        // HeadWidth=6, body 3 flits, last eofc 2 -> 4 flits, last eofc 4
        run_frame(6, 64'h0000_0605_0403_0201, 3, 8'd2, 8'hB0, "t1", 1'b1);
        chk("t1_hand_f0", 64'(q_data[0]), 64'h0403_0201);
        chk("t1_hand_f1", 64'(q_data[1]), 64'hB1B0_0605);
        chk("t1_hand_e3", 64'(q_eofc[3]), 64'd4);

        // HeadWidth=6, last eofc 3 -> tail flit {0,carry}, eofc 1
        run_frame(6, 64'h0000_0605_0403_0201, 3, 8'd3, 8'hB0, "t2", 1'b0);
        chk("t2_hand_tail", 64'(q_data[4]), 64'h0000_EEBA);
        chk("t2_hand_tail_e", 64'(q_eofc[4]), 64'd1);

        // HeadWidth=8 (no remainder): header flits then unchanged body
        sel = 1;
        run_frame(8, 64'h0807_0605_0403_0201, 2, 8'd4, 8'hB0, "t3", 1'b0);
        chk("t3_hand_f2", 64'(q_data[2]), 64'hB3B2_B1B0);
        chk("t3_hand_e2", 64'(q_eofc[2]), 64'd0);
        chk("t3_hand_e3", 64'(q_eofc[3]), 64'd4);

        // Random output backpressure with random frame shapes on both instances
        rnd_stop = 1'b1;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int fr = 0; fr < 20; fr++) begin
                run_frame((s == 0) ? 6 : 8, {$urandom, $urandom}, int'($urandom_range(1, 4)),
                          8'($urandom_range(1, 4)), 8'($urandom), $sformatf("rnd%0d_%0d", s, fr), 1'b0);
            end
        end
        rnd_stop = 1'b0;

        // Mid-frame reset with flits parked in the output buffer
        sel = 0;
        run_frame(6, 64'h0000_1615_1413_1211, 2, 8'd1, 8'h40, "sr1", 1'b0);
        force_stop = 1'b1;
        put_hdr(64'h0000_2625_2423_2221);
        put_flit(32'h5352_5150, 8'd0);
        repeat (6) @(posedge clk);
        #1;
        srst = 1'b1;
        @(posedge clk);
        #1;
        srst = 1'b0;
        force_stop = 1'b0;
        q_data.delete();
        q_eofc.delete();
        repeat (10) @(negedge clk);
        chk("srst_quiet", 64'(q_data.size()), 64'd0);
        chk("srst_in_stop", 64'(i_stop6), 64'd0);
        @(posedge clk);
        #1;
        run_frame(6, 64'h0000_3635_3433_3231, 3, 8'd3, 8'h60, "sr3", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
